// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Writeback sources, register-file write port and ID hazard
//               probe bundled for the writeback port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              p_wr;
    logic [ADDR_W-1:0] p_waddr;
    logic [DATA_W-1:0] p_din;
    logic              p_ready;
    logic              md_valid;
    logic [ADDR_W-1:0] md_waddr;
    logic [DATA_W-1:0] md_din;
    logic              md_ready;
    logic              rf_wr;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_din;
    logic [ADDR_W-1:0] chk_raddr1;
    logic [ADDR_W-1:0] chk_raddr2;
    logic              hazard1;
    logic              hazard2;

    modport master (
        output p_wr, p_waddr, p_din, md_valid, md_waddr, md_din,
               chk_raddr1, chk_raddr2,
        input  p_ready, md_ready, rf_wr, rf_waddr, rf_din, hazard1, hazard2
    );

    modport slave (
        input  p_wr, p_waddr, p_din, md_valid, md_waddr, md_din,
               chk_raddr1, chk_raddr2,
        output p_ready, md_ready, rf_wr, rf_waddr, rf_din, hazard1, hazard2
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the pipeline WB
//               stage and a FIFO-buffered mul/div unit, with WAW squash.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wb_port_arbiter_if.slave bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_FULL       = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_STV_W-1:0] c_STARVE_MAX = c_STV_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0]  c_R0         = '0;

    logic              r_live [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_STV_W-1:0] r_starve;

    logic              r_rf_wr;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_din;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_grant_p;
    logic w_grant_m;
    logic w_p_nz;
    logic w_hz1;
    logic w_hz2;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_push  = bus.md_valid && !w_full;
    assign w_p_nz  = (bus.p_waddr != c_R0);

    always_comb begin
        w_grant_p = 1'b0;
        w_grant_m = 1'b0;
        if (w_empty) begin
            w_grant_p = bus.p_wr;
        end else if (!bus.p_wr || (r_starve == c_STARVE_MAX)) begin
            w_grant_m = 1'b1;
        end else begin
            w_grant_p = 1'b1;
        end
    end

    // Live entries only ever occupy FIFO slots, so the scan needs no occupancy mask.
    always_comb begin
        w_hz1 = bus.rf_wr && (bus.rf_waddr == bus.chk_raddr1);
        w_hz2 = bus.rf_wr && (bus.rf_waddr == bus.chk_raddr2);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_live[i] && (r_addr[i] == bus.chk_raddr1)) w_hz1 = 1'b1;
            if (r_live[i] && (r_addr[i] == bus.chk_raddr2)) w_hz2 = 1'b1;
        end
    end

    assign bus.hazard1  = w_hz1 && (bus.chk_raddr1 != c_R0);
    assign bus.hazard2  = w_hz2 && (bus.chk_raddr2 != c_R0);
    assign bus.p_ready  = !bus.p_wr || w_grant_p;
    assign bus.md_ready = !w_full;
    assign bus.rf_wr    = r_rf_wr;
    assign bus.rf_waddr = r_rf_waddr;
    assign bus.rf_din   = r_rf_din;

    // Squash first, then pop/push: a same-cycle push lands in a free slot and stays live.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_live[i] <= 1'b0;
        end else begin
            if (w_grant_p && w_p_nz) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (r_live[i] && (r_addr[i] == bus.p_waddr)) r_live[i] <= 1'b0;
                end
            end
            if (w_grant_m) r_live[r_rptr] <= 1'b0;
            if (w_push)    r_live[r_wptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= bus.md_waddr;
            r_data[r_wptr] <= bus.md_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push)    r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_grant_m) r_rptr <= r_rptr + c_PTR_W'(1);
            case ({w_push, w_grant_m})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_grant_m || w_empty) begin
                r_starve <= '0;
            end else if (w_grant_p && (r_starve != c_STARVE_MAX)) begin
                r_starve <= r_starve + c_STV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wr    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_din   <= '0;
        end else if (w_grant_p) begin
            r_rf_wr    <= w_p_nz;
            r_rf_waddr <= bus.p_waddr;
            r_rf_din   <= bus.p_din;
        end else if (w_grant_m) begin
            r_rf_wr    <= r_live[r_rptr] && (r_addr[r_rptr] != c_R0);
            r_rf_waddr <= r_addr[r_rptr];
            r_rf_din   <= r_data[r_rptr];
        end else begin
            r_rf_wr    <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench for wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] shadow [32];

    wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_port_arbiter #(
        .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .STARVE_MAX(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural register image built from the committed write port.
    always @(posedge clk) begin
        if (bus.rf_wr) shadow[bus.rf_waddr] <= bus.rf_din;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_p(input logic wr, input logic [4:0] a, input logic [31:0] d);
        bus.p_wr = wr; bus.p_waddr = a; bus.p_din = d;
    endtask

    task automatic drive_m(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.md_valid = v; bus.md_waddr = a; bus.md_din = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step; step;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.rf_wr !== 1'b0) begin n_errors++; $display("FAIL rst_rf_wr got %0h exp 0", bus.rf_wr); end
        n_checks++; if (bus.rf_waddr !== 5'd0) begin n_errors++; $display("FAIL rst_rf_waddr got %0h exp 0", bus.rf_waddr); end
        n_checks++; if (bus.rf_din !== 32'd0) begin n_errors++; $display("FAIL rst_rf_din got %0h exp 0", bus.rf_din); end
        n_checks++; if (bus.md_ready !== 1'b1) begin n_errors++; $display("FAIL rst_md_ready got %0h exp 1", bus.md_ready); end
        n_checks++; if (bus.p_ready !== 1'b1) begin n_errors++; $display("FAIL rst_p_ready got %0h exp 1", bus.p_ready); end
        n_checks++; if (bus.hazard1 !== 1'b0 || bus.hazard2 !== 1'b0) begin n_errors++; $display("FAIL rst_hazard got %0b%0b exp 00", bus.hazard1, bus.hazard2); end
    endtask

    task automatic test_p_write;
        drive_p(1'b1, 5'd7, 32'h1234);
        bus.chk_raddr1 = 5'd7;
        step;
        drive_p(1'b0, 5'd0, 32'h0);
        #1;
        n_checks++; if (bus.rf_wr !== 1'b1) begin n_errors++; $display("FAIL p7_rf_wr got %0h exp 1", bus.rf_wr); end
        n_checks++; if (bus.rf_waddr !== 5'd7) begin n_errors++; $display("FAIL p7_rf_waddr got %0h exp 7", bus.rf_waddr); end
        n_checks++; if (bus.rf_din !== 32'h1234) begin n_errors++; $display("FAIL p7_rf_din got %0h exp 1234", bus.rf_din); end
        n_checks++; if (bus.hazard1 !== 1'b1) begin n_errors++; $display("FAIL p7_hazard1 got %0h exp 1", bus.hazard1); end
        drive_p(1'b1, 5'd0, 32'h55);
        step;
        drive_p(1'b0, 5'd0, 32'h0);
        #1;
        n_checks++; if (bus.rf_wr !== 1'b0) begin n_errors++; $display("FAIL p0_rf_wr got %0h exp 0", bus.rf_wr); end
        n_checks++; if (bus.rf_din !== 32'h55) begin n_errors++; $display("FAIL p0_rf_din got %0h exp 55", bus.rf_din); end
        step;
        bus.chk_raddr1 = 5'd0;
    endtask

    task automatic test_starve;
        drive_m(1'b1, 5'd3, 32'hAAAA);
        #1;
        n_checks++; if (bus.md_ready !== 1'b1) begin n_errors++; $display("FAIL stv_md_ready got %0h exp 1", bus.md_ready); end
        step;
        drive_m(1'b0, 5'd0, 32'h0);
        drive_p(1'b1, 5'd4, 32'h40);
        bus.chk_raddr1 = 5'd3;
        #1;
        n_checks++; if (bus.p_ready !== 1'b1) begin n_errors++; $display("FAIL stv_p4_ready got %0h exp 1", bus.p_ready); end
        n_checks++; if (bus.hazard1 !== 1'b1) begin n_errors++; $display("FAIL stv_hz_fifo got %0h exp 1", bus.hazard1); end
        step;
        drive_p(1'b1, 5'd5, 32'h50);
        #1;
        n_checks++; if (bus.p_ready !== 1'b1) begin n_errors++; $display("FAIL stv_p5_ready got %0h exp 1", bus.p_ready); end
        n_checks++; if (bus.rf_waddr !== 5'd4) begin n_errors++; $display("FAIL stv_rf_p4 got %0h exp 4", bus.rf_waddr); end
        step;
        drive_p(1'b1, 5'd6, 32'h60);
        #1;
        n_checks++; if (bus.p_ready !== 1'b1) begin n_errors++; $display("FAIL stv_p6_ready got %0h exp 1", bus.p_ready); end
        step;
        drive_p(1'b1, 5'd8, 32'h80);
        #1;
        n_checks++; if (bus.p_ready !== 1'b0) begin n_errors++; $display("FAIL stv_forced_stall got %0h exp 0", bus.p_ready); end
        step;
        #1;
        n_checks++; if (bus.p_ready !== 1'b1) begin n_errors++; $display("FAIL stv_p8_resume got %0h exp 1", bus.p_ready); end
        n_checks++; if (bus.rf_wr !== 1'b1 || bus.rf_waddr !== 5'd3) begin n_errors++; $display("FAIL stv_m_commit got wr=%0h a=%0h exp wr=1 a=3", bus.rf_wr, bus.rf_waddr); end
        n_checks++; if (bus.rf_din !== 32'hAAAA) begin n_errors++; $display("FAIL stv_m_data got %0h exp aaaa", bus.rf_din); end
        step;
        drive_p(1'b0, 5'd0, 32'h0);
        #1;
        n_checks++; if (bus.rf_waddr !== 5'd8 || bus.rf_din !== 32'h80) begin n_errors++; $display("FAIL stv_p8_commit got a=%0h d=%0h exp a=8 d=80", bus.rf_waddr, bus.rf_din); end
        n_checks++; if (bus.hazard1 !== 1'b0) begin n_errors++; $display("FAIL stv_hz_clear got %0h exp 0", bus.hazard1); end
        step;
        bus.chk_raddr1 = 5'd0;
    endtask

    task automatic test_full_wrap;
        drive_m(1'b1, 5'd10, 32'hA0);
        drive_p(1'b1, 5'd20, 32'h200);
        #1;
        n_checks++; if (bus.md_ready !== 1'b1 || bus.p_ready !== 1'b1) begin n_errors++; $display("FAIL full_c1 got mr=%0h pr=%0h exp 1 1", bus.md_ready, bus.p_ready); end
        step;
        drive_m(1'b1, 5'd11, 32'hB0);
        drive_p(1'b1, 5'd21, 32'h201);
        step;
        drive_m(1'b1, 5'd12, 32'hC0);
        drive_p(1'b1, 5'd22, 32'h202);
        bus.chk_raddr1 = 5'd10;
        bus.chk_raddr2 = 5'd12;
        #1;
        n_checks++; if (bus.md_ready !== 1'b0) begin n_errors++; $display("FAIL full_md_ready got %0h exp 0", bus.md_ready); end
        n_checks++; if (bus.p_ready !== 1'b1) begin n_errors++; $display("FAIL full_p22_ready got %0h exp 1", bus.p_ready); end
        n_checks++; if (bus.hazard1 !== 1'b1 || bus.hazard2 !== 1'b0) begin n_errors++; $display("FAIL full_hazards got %0b%0b exp 10", bus.hazard1, bus.hazard2); end
        step;
        drive_m(1'b0, 5'd0, 32'h0);
        drive_p(1'b1, 5'd23, 32'h203);
        #1;
        n_checks++; if (bus.p_ready !== 1'b1) begin n_errors++; $display("FAIL full_p23_ready got %0h exp 1", bus.p_ready); end
        step;
        drive_p(1'b1, 5'd24, 32'h204);
        #1;
        n_checks++; if (bus.p_ready !== 1'b0) begin n_errors++; $display("FAIL full_stall1 got %0h exp 0", bus.p_ready); end
        step;
        #1;
        n_checks++; if (bus.rf_waddr !== 5'd10 || bus.rf_din !== 32'hA0 || bus.rf_wr !== 1'b1) begin n_errors++; $display("FAIL full_pop1 got wr=%0h a=%0h d=%0h exp 1 a a0", bus.rf_wr, bus.rf_waddr, bus.rf_din); end
        n_checks++; if (bus.md_ready !== 1'b1) begin n_errors++; $display("FAIL full_md_ready_back got %0h exp 1", bus.md_ready); end
        step;
        drive_p(1'b1, 5'd25, 32'h205);
        step;
        drive_p(1'b1, 5'd26, 32'h206);
        step;
        drive_p(1'b1, 5'd27, 32'h207);
        #1;
        n_checks++; if (bus.p_ready !== 1'b0) begin n_errors++; $display("FAIL full_stall2 got %0h exp 0", bus.p_ready); end
        step;
        #1;
        n_checks++; if (bus.rf_waddr !== 5'd11 || bus.rf_din !== 32'hB0) begin n_errors++; $display("FAIL full_pop2 got a=%0h d=%0h exp b b0", bus.rf_waddr, bus.rf_din); end
        step;
        drive_p(1'b0, 5'd0, 32'h0);
        #1;
        n_checks++; if (bus.rf_waddr !== 5'd27) begin n_errors++; $display("FAIL full_p27 got %0h exp 1b", bus.rf_waddr); end
        step;
        #1;
        n_checks++; if (bus.rf_wr !== 1'b0) begin n_errors++; $display("FAIL full_no_third got %0h exp 0", bus.rf_wr); end
        bus.chk_raddr1 = 5'd0;
        bus.chk_raddr2 = 5'd0;
    endtask

    task automatic test_waw;
        drive_m(1'b1, 5'd9, 32'h9999);
        step;
        drive_m(1'b0, 5'd0, 32'h0);
        drive_p(1'b1, 5'd9, 32'h1111);
        bus.chk_raddr1 = 5'd9;
        #1;
        n_checks++; if (bus.hazard1 !== 1'b1) begin n_errors++; $display("FAIL waw_hz_pre got %0h exp 1", bus.hazard1); end
        step;
        drive_p(1'b0, 5'd0, 32'h0);
        #1;
        n_checks++; if (bus.rf_wr !== 1'b1 || bus.rf_din !== 32'h1111) begin n_errors++; $display("FAIL waw_p_commit got wr=%0h d=%0h exp 1 1111", bus.rf_wr, bus.rf_din); end
        step;
        #1;
        n_checks++; if (bus.rf_wr !== 1'b0) begin n_errors++; $display("FAIL waw_dead_pop got %0h exp 0", bus.rf_wr); end
        n_checks++; if (bus.hazard1 !== 1'b0) begin n_errors++; $display("FAIL waw_hz_post got %0h exp 0", bus.hazard1); end
        step;
        n_checks++; if (shadow[9] !== 32'h1111) begin n_errors++; $display("FAIL waw_reg9 got %0h exp 1111", shadow[9]); end
        bus.chk_raddr1 = 5'd0;
    endtask

    task automatic test_same_cycle_push;
        drive_m(1'b1, 5'd17, 32'h717);
        drive_p(1'b1, 5'd17, 32'h170);
        step;
        drive_m(1'b0, 5'd0, 32'h0);
        drive_p(1'b0, 5'd0, 32'h0);
        #1;
        n_checks++; if (bus.rf_din !== 32'h170) begin n_errors++; $display("FAIL sc_p_commit got %0h exp 170", bus.rf_din); end
        step;
        #1;
        n_checks++; if (bus.rf_wr !== 1'b1 || bus.rf_din !== 32'h717) begin n_errors++; $display("FAIL sc_m_live got wr=%0h d=%0h exp 1 717", bus.rf_wr, bus.rf_din); end
        step;
    endtask

    task automatic test_reset_mid;
        drive_m(1'b1, 5'd13, 32'hD0);
        drive_p(1'b1, 5'd14, 32'h140);
        step;
        drive_m(1'b1, 5'd15, 32'hE0);
        drive_p(1'b1, 5'd16, 32'h160);
        step;
        drive_m(1'b0, 5'd0, 32'h0);
        drive_p(1'b0, 5'd0, 32'h0);
        bus.chk_raddr1 = 5'd13;
        bus.chk_raddr2 = 5'd15;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.rf_wr !== 1'b1 || bus.hazard1 !== 1'b1) begin n_errors++; $display("FAIL rm_pre got wr=%0h hz=%0h exp 1 1", bus.rf_wr, bus.hazard1); end
        step;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.rf_wr !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_din !== 32'd0) begin n_errors++; $display("FAIL rm_rf got wr=%0h a=%0h d=%0h exp 0 0 0", bus.rf_wr, bus.rf_waddr, bus.rf_din); end
        n_checks++; if (bus.md_ready !== 1'b1) begin n_errors++; $display("FAIL rm_md_ready got %0h exp 1", bus.md_ready); end
        n_checks++; if (bus.hazard1 !== 1'b0 || bus.hazard2 !== 1'b0) begin n_errors++; $display("FAIL rm_hazard got %0b%0b exp 00", bus.hazard1, bus.hazard2); end
        step;
        #1;
        n_checks++; if (bus.rf_wr !== 1'b0) begin n_errors++; $display("FAIL rm_discard got %0h exp 0", bus.rf_wr); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive_p(1'b0, 5'd0, 32'h0);
        drive_m(1'b0, 5'd0, 32'h0);
        bus.chk_raddr1 = 5'd0;
        bus.chk_raddr2 = 5'd0;
        test_reset;
        test_p_write;
        test_starve;
        test_full_wrap;
        test_waw;
        test_same_cycle_push;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
- Source P is the in-order pipeline WB stage. Source M is the multicycle mul/div unit, buffered in a small FIFO.
- Sits between WB/mul-div and the register file's wr/waddr/din inputs.
- Provides starvation-bounded arbitration, WAW squash, and pending-write hazard flags for ID-stage reads.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, M-side buffer entries (power of two, >=2)
- STARVE_MAX, 3, consecutive P grants tolerated while FIFO non-empty before M is forced

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- p_wr  in  1  pipeline write request
- p_waddr  in  ADDR_W  pipeline destination register
- p_din  in  DATA_W  pipeline write data
- p_ready  out  1  P granted this cycle; when low with p_wr high, WB must hold request and stall
- md_valid  in  1  mul/div result valid
- md_waddr  in  ADDR_W  mul/div destination register
- md_din  in  DATA_W  mul/div result
- md_ready  out  1  FIFO can accept (=!full)
- rf_wr  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_din  out  DATA_W  register-file write data (registered)
- chk_raddr1, chk_raddr2  in  ADDR_W  ID-stage source registers
- hazard1, hazard2  out  1  combinational: source has a write not yet committed

Behaviour:
- Reset, synchronous:
  - Clears FIFO pointers, count and all entry valid bits, and starve_cnt.
  - rf_wr=0, rf_waddr=0, rf_din=0.
  - md_ready=1 from the first cycle after reset.
  - Reset mid-operation discards buffered M results.
- FIFO push: on md_valid && md_ready. Each entry stores {live, waddr, data}, with live=1 on push. Push and pop in the same cycle are legal; count is unchanged.
- Grant decision, combinational, each cycle:
  - FIFO empty: grant P if p_wr.
  - FIFO non-empty, !p_wr: grant M (pop head).
  - FIFO non-empty, p_wr, starve_cnt==STARVE_MAX: grant M, p_ready=0.
  - Otherwise: grant P, p_ready=1.
  - p_ready is also 1 whenever p_wr=0.
- starve_cnt:
  - Increments on a P grant while the FIFO is non-empty.
  - Clears on an M grant or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- Write port output, one cycle latency:
  - The granted source's addr/data are registered into rf_waddr/rf_din.
  - rf_wr=1 only when addr != 0 and, for M, the head entry is live.
  - A P write to r0, or a popped dead M entry, still consumes the grant but gives rf_wr=0.
  - rf_waddr/rf_din hold their last value when nothing is granted.
- WAW squash: on a P grant with p_waddr != 0, every FIFO entry with live=1 and waddr==p_waddr gets live=0 in that cycle. The later pipeline write supersedes the older mul/div result.
- A same-cycle push whose md_waddr equals a granted p_waddr is pushed live. The M result is logically younger.
- Hazards: hazardN=1 iff chk_raddrN != 0 and it matches either:
  - any live FIFO entry's waddr, or
  - rf_waddr while rf_wr=1.
  Dead entries never raise a hazard.
- Boundaries:
  - FIFO full: md_ready=0 and md_valid is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Worst-case P stall is 1 cycle per STARVE_MAX+1 cycles.
  - Worst-case M wait is STARVE_MAX cycles.

Test Plan:
- Reset, then idle → rf_wr=0, md_ready=1, hazard1=hazard2=0, p_ready=1.
- p_wr=1, p_waddr=7, p_din=0x1234 for one cycle → next cycle rf_wr=1, rf_waddr=7, rf_din=0x1234. p_waddr=0 variant → rf_wr=0.
- Push M (waddr=3, 0xAAAA) while p_wr held high with distinct addresses 4,5,6,8 → P granted 3 cycles, 4th cycle p_ready=0. The following cycle shows rf_waddr=3, rf_din=0xAAAA, then P resumes.
- Push M waddr=9, then a P write to 9 before it drains → entry marked dead. Pop produces rf_wr=0. Final reg 9 holds P data. hazard on chk_raddr1=9 drops after the P commit.
- Push 2 M results back-to-back with p_wr held on non-matching regs → md_ready=0 while full. A third md_valid is not accepted. Both drain in order via forced grants with wrap-around.
- Assert rst with 2 entries buffered and rf_wr high → next cycle count=0, rf_wr=0, hazards clear.
